// File: rtl/ws281x_decoder.sv
// WS281x NRZ receiver: pulse-width bit decode, 24-bit pixel assembly, frame-gap detect.
// Define WS281X_DEBOUNCE_EN to add a 3-sample stability filter after the synchronizer.
module ws281x_decoder #(
    parameter int ADDR_WIDTH = 6,
    parameter int PIXEL_NUM  = 64
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  ws281x_code_in,
    input  logic [7:0]            t_thr_cnt_in,
    input  logic [15:0]           rst_cnt_in,
    output logic                  pixel_valid_out,
    output logic [ADDR_WIDTH-1:0] pixel_addr_out,
    output logic [23:0]           pixel_data_out,
    output logic                  frame_done_out,
    output logic                  frame_err_out
);

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam logic [ADDR_WIDTH:0] PIX_LIM = (ADDR_WIDTH + 1)'(PIXEL_NUM);
    localparam logic [ADDR_WIDTH:0] PIX_ONE = (ADDR_WIDTH + 1)'(1);

    state_t state;
    state_t state_nxt;

    logic s1;
    logic s2;
    logic s3;
    logic lvl;
    logic rise;
    logic fall;

    logic [7:0]  high_cnt;
    logic [15:0] low_cnt;
    logic [15:0] rst_eff;
    logic        gap;

    logic [4:0]            bit_cnt;
    logic [23:0]           word;
    logic [ADDR_WIDTH:0]   pix_cnt;
    logic                  ovf;

    logic word_full;
    logic bit_take;
    logic bit_val;
    logic emit;
    logic frame_end;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= ws281x_code_in;
            s2 <= s1;
            s3 <= lvl;
        end
    end

`ifdef WS281X_DEBOUNCE_EN
    logic d1;
    logic d2;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            d1 <= s2;
            d2 <= d1;
        end
    end

    // s3 doubles as the held filter output; it moves only on 3 equal samples
    assign lvl = (s2 == d1 && d1 == d2) ? s2 : s3;
`else
    assign lvl = s2;
`endif

    assign rise = lvl & ~s3;
    assign fall = ~lvl & s3;

    // The edge cycle itself counts as the first cycle of the new level
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            high_cnt <= 8'd0;
            low_cnt  <= 16'd0;
        end else begin
            if (rise) begin
                high_cnt <= 8'd1;
            end else if (lvl && high_cnt != 8'hFF) begin
                high_cnt <= high_cnt + 8'd1;
            end
            if (fall) begin
                low_cnt <= 16'd1;
            end else if (!lvl && low_cnt != 16'hFFFF) begin
                low_cnt <= low_cnt + 16'd1;
            end
        end
    end

    assign rst_eff   = (rst_cnt_in == 16'd0) ? 16'd1 : rst_cnt_in;
    assign gap       = !lvl && (low_cnt >= rst_eff);
    assign word_full = (bit_cnt == 5'd24);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // A completed word is flushed before the frame may close
    always_comb begin
        state_nxt = state;
        unique case (state)
            SYNC: if (gap) state_nxt = IDLE;
            IDLE: if (rise) state_nxt = HIGH;
            HIGH: if (fall) state_nxt = LOW;
            LOW: begin
                if (rise) begin
                    state_nxt = HIGH;
                end else if (gap && !word_full) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        bit_take  = (state == HIGH) && fall;
        bit_val   = high_cnt > t_thr_cnt_in;
        emit      = word_full && (pix_cnt < PIX_LIM);
        frame_end = (state == LOW) && !rise && gap && !word_full;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pixel_valid_out <= 1'b0;
            pixel_addr_out  <= '0;
            pixel_data_out  <= 24'd0;
            frame_done_out  <= 1'b0;
            frame_err_out   <= 1'b0;
            bit_cnt         <= 5'd0;
            word            <= 24'd0;
            pix_cnt         <= '0;
            ovf             <= 1'b0;
        end else begin
            pixel_valid_out <= 1'b0;
            frame_done_out  <= 1'b0;
            frame_err_out   <= 1'b0;
            if (state == IDLE && rise) begin
                bit_cnt <= 5'd0;
                pix_cnt <= '0;
                ovf     <= 1'b0;
            end else if (frame_end) begin
                frame_done_out <= (pix_cnt != '0) || (bit_cnt != 5'd0);
                frame_err_out  <= (bit_cnt != 5'd0) || ovf;
                bit_cnt        <= 5'd0;
                pix_cnt        <= '0;
                ovf            <= 1'b0;
            end else if (bit_take) begin
                word    <= {word[22:0], bit_val};
                bit_cnt <= bit_cnt + 5'd1;
            end else if (word_full) begin
                bit_cnt <= 5'd0;
                if (emit) begin
                    pixel_valid_out <= 1'b1;
                    pixel_data_out  <= word;
                    pixel_addr_out  <= pix_cnt[ADDR_WIDTH-1:0];
                    pix_cnt         <= pix_cnt + PIX_ONE;
                end else begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ws281x_decoder.sv
// Randomized bench for ws281x_decoder against a frame-level reference model.
// Build with WS281X_DEBOUNCE_EN defined to also exercise the glitch filter.
`timescale 1ns/1ps
module tb_ws281x_decoder;

    localparam int AW = 2;
    localparam int PN = 4;
`ifdef WS281X_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        code = 1'b0;
    logic [7:0]  thr = 8'd50;
    logic [15:0] rst_cnt = 16'd1000;

    logic          valid;
    logic [AW-1:0] addr;
    logic [23:0]   data;
    logic          done;
    logic          err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int stray = 0;
    int glitch_at = -1;

    int          widths[$];
    int          lows[$];
    logic [23:0] pq_d[$];
    int          pq_a[$];
    int          pq_c[$];
    logic        fq_e[$];
    logic [23:0] ed[$];
    int          ea[$];
    logic        e_done;
    logic        e_err;

    ws281x_decoder #(
        .ADDR_WIDTH(AW),
        .PIXEL_NUM (PN)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .ws281x_code_in (code),
        .t_thr_cnt_in   (thr),
        .rst_cnt_in     (rst_cnt),
        .pixel_valid_out(valid),
        .pixel_addr_out (addr),
        .pixel_data_out (data),
        .frame_done_out (done),
        .frame_err_out  (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            pq_d.push_back(data);
            pq_a.push_back(int'(addr));
            pq_c.push_back(cyc);
        end
        if (done) fq_e.push_back(err);
        if (err && !done) stray++;
    end

    task automatic clr();
        widths.delete();
        lows.delete();
        pq_d.delete();
        pq_a.delete();
        pq_c.delete();
        fq_e.delete();
        glitch_at = -1;
    endtask

    task automatic add_bit(input int hi, input int lo);
        widths.push_back(hi);
        lows.push_back(lo);
    endtask

    task automatic add_word(input logic [23:0] w, input int h0, input int l0,
                            input int h1, input int l1);
        for (int b = 23; b >= 0; b--) begin
            if (w[b]) add_bit(h1, l1);
            else add_bit(h0, l0);
        end
    endtask

    task automatic play(input int gap);
        int lo;
        for (int i = 0; i < widths.size(); i++) begin
            code = 1'b1;
            repeat (widths[i]) @(negedge clk);
            code = 1'b0;
            fall_cyc = cyc;
            lo = (i == widths.size() - 1) ? gap : lows[i];
            if (i == glitch_at) begin
                repeat (20) @(negedge clk);
                code = 1'b1;
                repeat (2) @(negedge clk);
                code = 1'b0;
                lo = lo - 22;
            end
            repeat (lo) @(negedge clk);
        end
        if (widths.size() == 0) repeat (gap) @(negedge clk);
    endtask

    // Frame-level reference: bit = width > threshold, 24 bits per word, MSB first
    function automatic void model(input int pix);
        int nb;
        int nw;
        int wd;
        logic [23:0] w;
        nb = widths.size();
        nw = nb / 24;
        ed.delete();
        ea.delete();
        for (int k = 0; k < nw; k++) begin
            w = 24'd0;
            for (int b = 0; b < 24; b++) begin
                wd = (widths[k * 24 + b] > 255) ? 255 : widths[k * 24 + b];
                w = {w[22:0], wd > int'(thr)};
            end
            if (k < pix) begin
                ed.push_back(w);
                ea.push_back(k);
            end
        end
        e_done = nb > 0;
        e_err = (nb % 24 != 0) || (nw > pix);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        code = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", valid);
        end
        checks++;
        if (data !== 24'd0 || addr !== '0) begin
            errors++;
            $display("FAIL reset_pixel got %h/%0d want 0/0", data, addr);
        end
        checks++;
        if (done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame got %b%b want 00", done, err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sync();
        repeat (200) @(negedge clk);
        code = 1'b0;
        repeat (900) @(negedge clk);
        clr();
        add_word(24'hA5C30F, 10, 115, 100, 25);
        play(1200);
        checks++;
        if (pq_d.size() != 0 || fq_e.size() != 0) begin
            errors++;
            $display("FAIL sync_quiet got %0d px %0d frames want 0 0", pq_d.size(), fq_e.size());
        end
    endtask

    task automatic test_basic();
        clr();
        add_word(24'h010000, 10, 115, 100, 25);
        add_word(24'h00FFFF, 10, 115, 100, 25);
        play(1200);
        checks++;
        if (pq_d.size() != 2) begin
            errors++;
            $display("FAIL basic_count got %0d want 2", pq_d.size());
        end else begin
            checks++;
            if (pq_d[0] !== 24'h010000 || pq_a[0] != 0) begin
                errors++;
                $display("FAIL basic_px0 got %h@%0d want 010000@0", pq_d[0], pq_a[0]);
            end
            checks++;
            if (pq_d[1] !== 24'h00FFFF || pq_a[1] != 1) begin
                errors++;
                $display("FAIL basic_px1 got %h@%0d want 00ffff@1", pq_d[1], pq_a[1]);
            end
            checks++;
            if (pq_c[1] - fall_cyc != LAT) begin
                errors++;
                $display("FAIL basic_latency got %0d want %0d", pq_c[1] - fall_cyc, LAT);
            end
        end
        checks++;
        if (fq_e.size() != 1 || fq_e[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_frame got %0d frames want 1 clean", fq_e.size());
        end
        checks++;
        if (data !== 24'h00FFFF || addr !== 2'd1) begin
            errors++;
            $display("FAIL basic_hold got %h@%0d want 00ffff@1", data, addr);
        end
    endtask

    task automatic test_threshold();
        int opts[4] = '{49, 50, 51, 52};
        clr();
        thr = 8'd50;
        add_bit(50, 40);
        add_bit(51, 40);
        for (int i = 0; i < 22; i++) add_bit(opts[$urandom_range(0, 3)], 40);
        play(1200);
        model(PN);
        checks++;
        if (pq_d.size() != 1) begin
            errors++;
            $display("FAIL thr_count got %0d want 1", pq_d.size());
        end else begin
            checks++;
            if (pq_d[0][23:22] !== 2'b01) begin
                errors++;
                $display("FAIL thr_edge got %b want 01", pq_d[0][23:22]);
            end
            checks++;
            if (pq_d[0] !== ed[0]) begin
                errors++;
                $display("FAIL thr_word got %h want %h", pq_d[0], ed[0]);
            end
        end
    endtask

    task automatic test_partial();
        clr();
        for (int i = 0; i < 30; i++) add_bit(int'($urandom_range(5, 100)), 40);
        play(1200);
        model(PN);
        checks++;
        if (pq_d.size() != 1 || pq_d[0] !== ed[0]) begin
            errors++;
            $display("FAIL partial_px got %0d px want 1 of %h", pq_d.size(), ed[0]);
        end
        checks++;
        if (fq_e.size() != 1 || fq_e[0] !== 1'b1) begin
            errors++;
            $display("FAIL partial_err got %0d frames want 1 with err", fq_e.size());
        end
        clr();
        add_word(24'h5A5A5A, 10, 115, 100, 25);
        play(1200);
        checks++;
        if (pq_d.size() != 1 || pq_a[0] != 0 || pq_d[0] !== 24'h5A5A5A) begin
            errors++;
            $display("FAIL partial_next got %0d px want 5a5a5a@0", pq_d.size());
        end
    endtask

    task automatic test_overflow();
        clr();
        thr = 8'd30;
        for (int i = 0; i < 24 * (PN + 1); i++) add_bit(($urandom_range(0, 1) != 0) ? 60 : 8, 20);
        play(1200);
        model(PN);
        checks++;
        if (pq_d.size() != PN) begin
            errors++;
            $display("FAIL ovf_count got %0d want %0d", pq_d.size(), PN);
        end else begin
            for (int i = 0; i < PN; i++) begin
                checks++;
                if (pq_d[i] !== ed[i] || pq_a[i] != ea[i]) begin
                    errors++;
                    $display("FAIL ovf_px%0d got %h@%0d want %h@%0d", i, pq_d[i], pq_a[i], ed[i], ea[i]);
                end
            end
        end
        checks++;
        if (fq_e.size() != 1 || fq_e[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_err got %0d frames want 1 with err", fq_e.size());
        end
        thr = 8'd50;
    endtask

    task automatic test_rst_zero();
        clr();
        rst_cnt = 16'd0;
        add_bit(60, 0);
        play(10);
        checks++;
        if (pq_d.size() != 0 || fq_e.size() != 1 || fq_e[0] !== 1'b1) begin
            errors++;
            $display("FAIL rstzero got %0d px %0d frames want 0 px 1 err frame", pq_d.size(), fq_e.size());
        end
        rst_cnt = 16'd1000;
    endtask

    task automatic test_midreset();
        clr();
        for (int i = 0; i < 10; i++) add_bit(100, 40);
        play(40);
        code = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || data !== 24'd0 || addr !== '0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_out got %b %h %0d %b %b want all 0", valid, data, addr, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        for (int i = 0; i < 14; i++) add_bit(100, 40);
        play(1200);
        checks++;
        if (pq_d.size() != 0 || fq_e.size() != 0) begin
            errors++;
            $display("FAIL midrst_sync got %0d px %0d frames want 0 0", pq_d.size(), fq_e.size());
        end
        clr();
        add_word(24'hC0FFEE, 10, 115, 100, 25);
        play(1200);
        checks++;
        if (pq_d.size() != 1 || pq_d[0] !== 24'hC0FFEE || pq_a[0] != 0) begin
            errors++;
            $display("FAIL midrst_next got %0d px want c0ffee@0", pq_d.size());
        end
    endtask

`ifdef WS281X_DEBOUNCE_EN
    task automatic test_glitch();
        clr();
        add_word(24'h3C3C3C, 10, 115, 100, 60);
        glitch_at = 5;
        play(1200);
        checks++;
        if (pq_d.size() != 1 || pq_d[0] !== 24'h3C3C3C) begin
            errors++;
            $display("FAIL glitch got %0d px want 3c3c3c", pq_d.size());
        end
    endtask
`endif

    task automatic test_random();
        int nb;
        for (int it = 0; it < 4; it++) begin
            clr();
            thr = 8'($urandom_range(20, 80));
            rst_cnt = 16'($urandom_range(150, 400));
            nb = (it == 0) ? 0 : int'($urandom_range(1, 50));
            for (int i = 0; i < nb; i++) begin
                add_bit(int'($urandom_range(3, 120)), int'($urandom_range(5, 100)));
            end
            play(int'(rst_cnt) + 30);
            model(PN);
            checks++;
            if (pq_d.size() != ed.size()) begin
                errors++;
                $display("FAIL rand%0d_count got %0d want %0d", it, pq_d.size(), ed.size());
            end else begin
                for (int i = 0; i < ed.size(); i++) begin
                    checks++;
                    if (pq_d[i] !== ed[i] || pq_a[i] != ea[i]) begin
                        errors++;
                        $display("FAIL rand%0d_px%0d got %h@%0d want %h@%0d", it, i, pq_d[i], pq_a[i], ed[i], ea[i]);
                    end
                end
            end
            checks++;
            if (fq_e.size() != (e_done ? 1 : 0)) begin
                errors++;
                $display("FAIL rand%0d_frames got %0d want %0d", it, fq_e.size(), e_done);
            end else if (e_done) begin
                checks++;
                if (fq_e[0] !== e_err) begin
                    errors++;
                    $display("FAIL rand%0d_err got %b want %b", it, fq_e[0], e_err);
                end
            end
        end
        thr = 8'd50;
        rst_cnt = 16'd1000;
    endtask

    initial begin
        test_reset();
        test_sync();
        test_basic();
        test_threshold();
        test_partial();
        test_overflow();
        test_rst_zero();
        test_midreset();
`ifdef WS281X_DEBOUNCE_EN
        test_glitch();
`endif
        test_random();
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL stray_err got %0d want 0", stray);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
